// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit front-end for a byte-serial UART transmitter that has no busy
//   output. Bytes from the store path are buffered in a DEPTH-entry FIFO and
//   issued as single-cycle write strobes, spaced GAP_CYCLES clocks apart so
//   that each frame has finished before the next byte is handed over.
//
// Ports
//   sys_clk_i   : system clock (100 MHz)
//   sys_rstn_i  : asynchronous active-low reset
//   wr_en_i     : push wr_dat_i this cycle (dropped when full_o is set)
//   wr_dat_i    : byte to transmit
//   clr_ovf_i   : clear the sticky overflow flag
//   full_o      : FIFO holds DEPTH entries (registered)
//   empty_o     : FIFO holds no entries (registered)
//   count_o     : FIFO occupancy
//   ovf_o       : sticky, a write was dropped because the FIFO was full
//   busy_o      : FIFO non-empty or a frame gap still running
//   uart_wr_o   : one-cycle write strobe to the transmitter
//   uart_dat_o  : byte for the transmitter, held until the next pop
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 9600
) (
  input  logic          sys_clk_i,
  input  logic          sys_rstn_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_dat_i,
  input  logic          clr_ovf_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          busy_o,
  output logic          uart_wr_o,
  output logic [7:0]    uart_dat_o
);

  localparam int          GW       = $clog2(GAP_CYCLES);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 2);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          uart_wr_q, uart_wr_d;
  logic [7:0]    uart_dat_q, uart_dat_d;
  logic [GW-1:0] gap_q, gap_d;
  state_e        state_q, state_d;
  logic          avail_q;

  logic push, drop, pop;

  // full_q is the registered flag, so a write arriving while full is dropped
  // even if a pop frees a slot on the same edge.
  assign push = wr_en_i & ~full_q;
  assign drop = wr_en_i &  full_q;

  // The pacer looks at the non-empty flag one cycle late, which fixes the
  // push-to-strobe latency at two clocks for a byte entering an empty FIFO.
  assign pop  = (state_q == ST_IDLE) & avail_q & ~empty_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    gap_d      = gap_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          uart_dat_d = mem_q[rd_ptr_q];
          uart_wr_d  = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          gap_d      = GAP_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Loading GAP_CYCLES-2 plus the exit cycle and the IDLE pop cycle
        // spaces strobes exactly GAP_CYCLES apart.
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    busy_d  = ~empty_d | (state_d == ST_WAIT);

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
      gap_q      <= '0;
      state_q    <= ST_IDLE;
      avail_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
      gap_q      <= gap_d;
      state_q    <= state_d;
      avail_q    <= ~empty_q;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign busy_o     = busy_q;
  assign uart_wr_o  = uart_wr_q;
  assign uart_dat_o = uart_dat_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Three instances share clock and reset:
//   dut 0 uses the default 9600-clock gap, dut 1 a 64-clock gap (so a full
//   FIFO drains quickly), dut 2 a 4-clock gap for the pointer-wrap run.
//   A negedge monitor per instance logs every strobe with its edge number.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  logic       wr_en   [3];
  logic [7:0] wr_dat  [3];
  logic       clr_ovf [3];
  logic       full    [3];
  logic       empty   [3];
  logic [4:0] count   [3];
  logic       ovf     [3];
  logic       busy    [3];
  logic       uart_wr [3];
  logic [7:0] udat    [3];

  typedef struct {
    int         cyc;
    logic [7:0] dat;
    logic [4:0] cnt;
  } strobe_t;

  strobe_t q0[$];
  strobe_t q1[$];
  strobe_t q2[$];

  uart_tx_fifo #(.DEPTH(16), .AW(4), .GAP_CYCLES(9600)) u_slow (
    .sys_clk_i(clk), .sys_rstn_i(rst_n),
    .wr_en_i(wr_en[0]), .wr_dat_i(wr_dat[0]), .clr_ovf_i(clr_ovf[0]),
    .full_o(full[0]), .empty_o(empty[0]), .count_o(count[0]), .ovf_o(ovf[0]),
    .busy_o(busy[0]), .uart_wr_o(uart_wr[0]), .uart_dat_o(udat[0])
  );

  uart_tx_fifo #(.DEPTH(16), .AW(4), .GAP_CYCLES(64)) u_mid (
    .sys_clk_i(clk), .sys_rstn_i(rst_n),
    .wr_en_i(wr_en[1]), .wr_dat_i(wr_dat[1]), .clr_ovf_i(clr_ovf[1]),
    .full_o(full[1]), .empty_o(empty[1]), .count_o(count[1]), .ovf_o(ovf[1]),
    .busy_o(busy[1]), .uart_wr_o(uart_wr[1]), .uart_dat_o(udat[1])
  );

  uart_tx_fifo #(.DEPTH(16), .AW(4), .GAP_CYCLES(4)) u_fast (
    .sys_clk_i(clk), .sys_rstn_i(rst_n),
    .wr_en_i(wr_en[2]), .wr_dat_i(wr_dat[2]), .clr_ovf_i(clr_ovf[2]),
    .full_o(full[2]), .empty_o(empty[2]), .count_o(count[2]), .ovf_o(ovf[2]),
    .busy_o(busy[2]), .uart_wr_o(uart_wr[2]), .uart_dat_o(udat[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (uart_wr[0]) q0.push_back('{cyc, udat[0], count[0]});
    if (uart_wr[1]) q1.push_back('{cyc, udat[1], count[1]});
    if (uart_wr[2]) q2.push_back('{cyc, udat[2], count[2]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      vectors++; if (full[d] !== 1'b0) begin miscompares++; $display("FAIL rst_full[%0d]: got %b exp 0", d, full[d]); end
      vectors++; if (empty[d] !== 1'b1) begin miscompares++; $display("FAIL rst_empty[%0d]: got %b exp 1", d, empty[d]); end
      vectors++; if (count[d] !== 5'd0) begin miscompares++; $display("FAIL rst_count[%0d]: got %0d exp 0", d, count[d]); end
      vectors++; if (ovf[d] !== 1'b0) begin miscompares++; $display("FAIL rst_ovf[%0d]: got %b exp 0", d, ovf[d]); end
      vectors++; if (busy[d] !== 1'b0) begin miscompares++; $display("FAIL rst_busy[%0d]: got %b exp 0", d, busy[d]); end
      vectors++; if (uart_wr[d] !== 1'b0) begin miscompares++; $display("FAIL rst_wr[%0d]: got %b exp 0", d, uart_wr[d]); end
      vectors++; if (udat[d] !== 8'h00) begin miscompares++; $display("FAIL rst_dat[%0d]: got %h exp 00", d, udat[d]); end
    end
  endtask

  task automatic test_single_byte();
    int k;
    q0.delete();
    wr_en[0] = 1'b1; wr_dat[0] = 8'h41;
    tick(); k = cyc;
    wr_en[0] = 1'b0;
    vectors++; if (count[0] !== 5'd1) begin miscompares++; $display("FAIL single_cnt: got %0d exp 1", count[0]); end
    vectors++; if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL single_busy_push: got %b exp 1", busy[0]); end
    tick();
    vectors++; if (uart_wr[0] !== 1'b0) begin miscompares++; $display("FAIL single_early: got %b exp 0 at k+1", uart_wr[0]); end
    tick();
    vectors++; if (uart_wr[0] !== 1'b1) begin miscompares++; $display("FAIL single_strobe: got %b exp 1 at k+2", uart_wr[0]); end
    vectors++; if (udat[0] !== 8'h41) begin miscompares++; $display("FAIL single_dat: got %h exp 41", udat[0]); end
    vectors++; if (empty[0] !== 1'b1) begin miscompares++; $display("FAIL single_empty: got %b exp 1", empty[0]); end
    tick();
    vectors++; if (uart_wr[0] !== 1'b0) begin miscompares++; $display("FAIL single_width: got %b exp 0 at k+3", uart_wr[0]); end
    while (cyc < k + 2 + 9598) tick();
    vectors++; if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL single_busy_hold: got %b exp 1", busy[0]); end
    tick();
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %b exp 0", busy[0]); end
    repeat (50) tick();
    vectors++; if (q0.size() !== 1) begin miscompares++; $display("FAIL single_nstrobe: got %0d exp 1", q0.size()); end
    else begin
      vectors++; if (q0[0].cyc !== k + 2) begin miscompares++; $display("FAIL single_edge: got %0d exp %0d", q0[0].cyc, k + 2); end
    end
  endtask

  task automatic test_burst();
    int k;
    logic [7:0] exp_dat [3];
    logic [4:0] exp_cnt [3];
    exp_dat[0] = 8'h10; exp_dat[1] = 8'h20; exp_dat[2] = 8'h30;
    exp_cnt[0] = 5'd2;  exp_cnt[1] = 5'd1;  exp_cnt[2] = 5'd0;
    q0.delete();
    wr_en[0] = 1'b1; wr_dat[0] = 8'h10;
    tick(); k = cyc;
    vectors++; if (count[0] !== 5'd1) begin miscompares++; $display("FAIL burst_cnt0: got %0d exp 1", count[0]); end
    wr_dat[0] = 8'h20;
    tick();
    vectors++; if (count[0] !== 5'd2) begin miscompares++; $display("FAIL burst_cnt1: got %0d exp 2", count[0]); end
    wr_dat[0] = 8'h30;
    tick();
    wr_en[0] = 1'b0;
    vectors++; if (count[0] !== 5'd2) begin miscompares++; $display("FAIL burst_cnt2: got %0d exp 2", count[0]); end
    tick();
    vectors++; if (count[0] !== 5'd2) begin miscompares++; $display("FAIL burst_cnt3: got %0d exp 2", count[0]); end
    while (cyc < k + 2 + 2 * 9600 + 10) tick();
    vectors++; if (q0.size() !== 3) begin miscompares++; $display("FAIL burst_nstrobe: got %0d exp 3", q0.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        vectors++; if (q0[i].cyc !== k + 2 + i * 9600) begin miscompares++; $display("FAIL burst_edge[%0d]: got %0d exp %0d", i, q0[i].cyc, k + 2 + i * 9600); end
        vectors++; if (q0[i].dat !== exp_dat[i]) begin miscompares++; $display("FAIL burst_dat[%0d]: got %h exp %h", i, q0[i].dat, exp_dat[i]); end
        vectors++; if (q0[i].cnt !== exp_cnt[i]) begin miscompares++; $display("FAIL burst_strobe_cnt[%0d]: got %0d exp %0d", i, q0[i].cnt, exp_cnt[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    int k;
    q0.delete();
    repeat (9700) tick();
    for (int i = 0; i < 5; i++) begin
      wr_en[0] = 1'b1; wr_dat[0] = 8'hA1 + 8'(i);
      tick();
      if (i == 0) k = cyc;
    end
    wr_en[0] = 1'b0;
    while (cyc < k + 2 + 100) tick();
    vectors++; if (udat[0] !== 8'hA1) begin miscompares++; $display("FAIL rmg_first_dat: got %h exp a1", udat[0]); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (count[0] !== 5'd0) begin miscompares++; $display("FAIL rmg_count: got %0d exp 0", count[0]); end
    vectors++; if (empty[0] !== 1'b1) begin miscompares++; $display("FAIL rmg_empty: got %b exp 1", empty[0]); end
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL rmg_busy: got %b exp 0", busy[0]); end
    vectors++; if (udat[0] !== 8'h00) begin miscompares++; $display("FAIL rmg_dat: got %h exp 00", udat[0]); end
    vectors++; if (uart_wr[0] !== 1'b0) begin miscompares++; $display("FAIL rmg_wr: got %b exp 0", uart_wr[0]); end
    tick();
    #3 rst_n = 1'b1;
    q0.delete();
    repeat (9700) tick();
    vectors++; if (q0.size() !== 0) begin miscompares++; $display("FAIL rmg_no_strobe: got %0d strobes exp 0", q0.size()); end
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL rmg_idle_busy: got %b exp 0", busy[0]); end
    wr_en[0] = 1'b1; wr_dat[0] = 8'h5A;
    tick(); k = cyc;
    wr_en[0] = 1'b0;
    repeat (5) tick();
    vectors++; if (q0.size() !== 1) begin miscompares++; $display("FAIL rmg_new_nstrobe: got %0d exp 1", q0.size()); end
    else begin
      vectors++; if (q0[0].cyc !== k + 2) begin miscompares++; $display("FAIL rmg_new_edge: got %0d exp %0d", q0[0].cyc, k + 2); end
      vectors++; if (q0[0].dat !== 8'h5A) begin miscompares++; $display("FAIL rmg_new_dat: got %h exp 5a", q0[0].dat); end
    end
  endtask

  task automatic test_overflow();
    q1.delete();
    for (int i = 0; i < 18; i++) begin
      wr_en[1] = 1'b1; wr_dat[1] = 8'(i);
      tick();
      if (i == 16) begin
        vectors++; if (count[1] !== 5'd16) begin miscompares++; $display("FAIL ovf_cnt16: got %0d exp 16", count[1]); end
        vectors++; if (full[1] !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b exp 1", full[1]); end
        vectors++; if (ovf[1] !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b exp 0", ovf[1]); end
      end
    end
    wr_en[1] = 1'b0;
    vectors++; if (count[1] !== 5'd16) begin miscompares++; $display("FAIL ovf_cnt_drop: got %0d exp 16", count[1]); end
    vectors++; if (ovf[1] !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b exp 1", ovf[1]); end
    clr_ovf[1] = 1'b1;
    tick();
    clr_ovf[1] = 1'b0;
    vectors++; if (ovf[1] !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b exp 0", ovf[1]); end
    repeat (17 * 64 + 100) tick();
    vectors++; if (q1.size() !== 17) begin miscompares++; $display("FAIL ovf_nstrobe: got %0d exp 17", q1.size()); end
    else begin
      for (int i = 0; i < 17; i++) begin
        vectors++; if (q1[i].dat !== 8'(i)) begin miscompares++; $display("FAIL ovf_order[%0d]: got %h exp %h", i, q1[i].dat, 8'(i)); end
      end
    end
  endtask

  task automatic test_coincident();
    int k;
    q1.delete();
    for (int i = 0; i < 17; i++) begin
      wr_en[1] = 1'b1; wr_dat[1] = 8'hC0 + 8'(i);
      tick();
      if (i == 0) k = cyc;
    end
    wr_en[1] = 1'b0;
    vectors++; if (count[1] !== 5'd16) begin miscompares++; $display("FAIL coin_fill: got %0d exp 16", count[1]); end
    while (cyc < k + 65) tick();
    wr_en[1] = 1'b1; wr_dat[1] = 8'hEE;
    tick();
    vectors++; if (uart_wr[1] !== 1'b1) begin miscompares++; $display("FAIL coin_pop: got %b exp 1", uart_wr[1]); end
    vectors++; if (count[1] !== 5'd15) begin miscompares++; $display("FAIL coin_cnt15: got %0d exp 15", count[1]); end
    vectors++; if (ovf[1] !== 1'b1) begin miscompares++; $display("FAIL coin_ovf: got %b exp 1", ovf[1]); end
    wr_dat[1] = 8'hEF; clr_ovf[1] = 1'b1;
    tick();
    wr_en[1] = 1'b0; clr_ovf[1] = 1'b0;
    vectors++; if (count[1] !== 5'd16) begin miscompares++; $display("FAIL coin_cnt16: got %0d exp 16", count[1]); end
    vectors++; if (ovf[1] !== 1'b0) begin miscompares++; $display("FAIL coin_clr: got %b exp 0", ovf[1]); end
    repeat (18 * 64 + 100) tick();
    vectors++; if (q1.size() !== 18) begin miscompares++; $display("FAIL coin_nstrobe: got %0d exp 18", q1.size()); end
    else begin
      for (int i = 0; i < 18; i++) begin
        logic [7:0] e;
        e = (i < 17) ? 8'hC0 + 8'(i) : 8'hEF;
        vectors++; if (q1[i].dat !== e) begin miscompares++; $display("FAIL coin_order[%0d]: got %h exp %h", i, q1[i].dat, e); end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    int guard;
    q2.delete();
    n = 0; guard = 0;
    while (n < 40 && guard < 1000) begin
      if (full[2] === 1'b0) begin
        wr_en[2] = 1'b1; wr_dat[2] = 8'(n); n++;
      end else begin
        wr_en[2] = 1'b0;
      end
      tick();
      guard++;
    end
    wr_en[2] = 1'b0;
    vectors++; if (n !== 40) begin miscompares++; $display("FAIL wrap_push_timeout: pushed %0d exp 40", n); end
    repeat (40 * 4 + 50) tick();
    vectors++; if (ovf[2] !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf: got %b exp 0", ovf[2]); end
    vectors++; if (q2.size() !== 40) begin miscompares++; $display("FAIL wrap_nstrobe: got %0d exp 40", q2.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        vectors++; if (q2[i].dat !== 8'(i)) begin miscompares++; $display("FAIL wrap_order[%0d]: got %h exp %h", i, q2[i].dat, 8'(i)); end
        if (i > 0) begin
          vectors++; if (q2[i].cyc - q2[i-1].cyc !== 4) begin miscompares++; $display("FAIL wrap_gap[%0d]: got %0d exp 4", i, q2[i].cyc - q2[i-1].cyc); end
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      wr_en[d] = 1'b0; wr_dat[d] = 8'h00; clr_ovf[d] = 1'b0;
    end
    #22 rst_n = 1'b1;
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_coincident();
    test_wrap();
    test_reset_mid_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit front-end that sits directly upstream of the byte-serial UART transmitter.
- Buffers bytes from the processor's store path in a DEPTH-entry FIFO.
- Issues them to the transmitter as single-cycle write strobes paced by a frame-gap counter, because the transmitter exposes no busy output.
- Drives the transmitter's uart_wr_i / uart_dat_i; runs on the same 100 MHz clock and reset.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, 4: pointer width; equals log2(DEPTH).
- GAP_CYCLES, 9600: clocks between successive uart_wr_o pulses. Must exceed one 11-bit frame at 115200 baud / 100 MHz (about 9549 clocks). Minimum 4.

Ports:
- sys_clk_i  input  1  system clock, 100 MHz
- sys_rstn_i  input  1  reset, asynchronous, active-low
- wr_en_i  input  1  push wr_dat_i into the FIFO this cycle
- wr_dat_i  input  8  byte to transmit
- clr_ovf_i  input  1  clear the sticky overflow flag
- full_o  output  1  FIFO holds DEPTH entries
- empty_o  output  1  FIFO holds 0 entries
- count_o  output  AW+1  current FIFO occupancy
- ovf_o  output  1  sticky: a write was dropped because the FIFO was full
- busy_o  output  1  FIFO non-empty or a gap is still running
- uart_wr_o  output  1  one-cycle write strobe to the transmitter
- uart_dat_o  output  8  byte for the transmitter; valid with uart_wr_o and held until the next pop

Behaviour:
- Interface: one clock, sys_clk_i. Reset sys_rstn_i is asynchronous and active-low. All state is in flops clocked on the rising edge of sys_clk_i.
- Reset values:
  - read/write pointers = 0, count = 0
  - full_o = 0, empty_o = 1, count_o = 0, ovf_o = 0, busy_o = 0
  - uart_wr_o = 0, uart_dat_o = 8'h00
  - state = IDLE, gap counter = 0
- Reset mid-operation discards all buffered bytes and any running gap; no strobe is issued after reset deasserts until a new write arrives.
- Storage: flop array, DEPTH x 8. Pointers are AW bits and wrap modulo DEPTH. count_o is a separate AW+1-bit register.
- Push: occurs when wr_en_i=1 and full_o=0 at the clock edge. Data goes to mem[wr_ptr]; wr_ptr increments.
- Full-write rule: with wr_en_i=1 and full_o=1, the byte is dropped and ovf_o is set to 1. This holds even if a pop happens in the same cycle, because full_o is the registered flag.
- ovf_o clearing: ovf_o clears on clr_ovf_i=1. If a dropped write coincides with clr_ovf_i, set wins.
- Simultaneous push and pop: both are performed and count is unchanged.
- Flags: full_o = (count==DEPTH), empty_o = (count==0). Both are registered, consistent with count_o in the same cycle.
- Pacer FSM, two states:
  - IDLE: if empty_o=0, pop: uart_dat_o <= mem[rd_ptr], uart_wr_o <= 1, rd_ptr++, count--, gap counter <= GAP_CYCLES-2, go to WAIT. Otherwise uart_wr_o <= 0.
  - WAIT: uart_wr_o <= 0. The gap counter decrements each cycle; when it reaches 0, go to IDLE.
- Timing:
  - Consecutive uart_wr_o rising edges are exactly GAP_CYCLES clocks apart while the FIFO stays non-empty.
  - uart_wr_o is never high for two consecutive cycles.
  - Latency: a byte pushed at edge k into an empty FIFO with the FSM in IDLE makes uart_wr_o=1 between edges k+2 and k+3, with uart_dat_o equal to that byte. The bench must check this exact cycle.
- busy_o = ~empty_o | (state==WAIT), registered. It falls GAP_CYCLES-1 cycles after the last strobe.
- Byte order out equals byte order in, across pointer wrap.

Test Plan:
- Single byte: reset, push 8'h41 at edge k -> uart_wr_o high for exactly one cycle at edge k+2, uart_dat_o=8'h41; busy_o low 9599 cycles after the strobe; no second strobe.
- Burst: push 8'h10, 8'h20, 8'h30 on three consecutive cycles -> three strobes exactly 9600 clocks apart carrying 10, 20, 30 in order; count_o goes 1, 2, 2, 2, then decrements at each later strobe.
- Overflow: push 18 bytes 8'h00..8'h11 on consecutive cycles -> first byte popped, count_o reaches 16 with full_o=1, byte 8'h11 dropped, ovf_o=1. Then pulse clr_ovf_i -> ovf_o=0. The 17 accepted bytes appear in order.
- Wrap: 40 bytes 0..39 pushed whenever full_o=0, with GAP_CYCLES=4 -> 40 strobes, uart_dat_o sequence 0..39, no loss, ovf_o stays 0.
- Reset mid-gap: 5 bytes queued, assert sys_rstn_i=0 asynchronously 100 cycles after the first strobe -> all outputs return to reset values immediately; after release, no strobes until a new push.
- Coincident events with count_o=16: pop and wr_en_i in the same cycle -> write dropped, ovf_o=1, count_o=15. Next cycle, a write together with clr_ovf_i -> write accepted, ovf_o=0.
